// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store request bundle between the pipeline
// and the data memory responder.
interface data_mem_responder_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        err;

  modport master (
    output mem_r_en, mem_w_en, addr, wr_data,
    input  rd_data, rd_valid, stall, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wr_data,
    output rd_data, rd_valid, stall, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: services MEM-stage loads/stores from a
// word array after WAIT_CYCLES wait states, stalling the pipeline.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rstn,
  data_mem_responder_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BASE  = 32'(BASE_ADDR);
  localparam logic [31:0] LIMIT = 32'(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [31:0]     rdata_q;
  logic            valid_q;
  logic            err_q;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic            illegal;
  logic [31:0]     idx32;
  logic            acc_wr, acc_rd, set_err;
  logic [IW-1:0]   acc_idx;
  logic [31:0]     acc_dat;

  assign req   = bus.mem_r_en | bus.mem_w_en;
  assign idx32 = (bus.addr - BASE) >> 2;

  // Out-of-range is an error, never aliased onto the array.
  assign illegal = (bus.addr[1:0] != 2'b00)
                || (bus.addr < BASE)
                || (idx32 >= LIMIT)
                || (bus.mem_r_en && bus.mem_w_en);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    set_err = 1'b0;
    acc_idx = idx_q;
    acc_dat = wdat_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            set_err = 1'b1;
            state_d = DONE;
          end else if (WAIT_CYCLES == 0) begin
            acc_wr  = bus.mem_w_en;
            acc_rd  = bus.mem_r_en;
            acc_idx = idx32[IW-1:0];
            acc_dat = bus.wr_data;
            state_d = DONE;
          end else begin
            we_d    = bus.mem_w_en;
            idx_d   = idx32[IW-1:0];
            wdat_d  = bus.wr_data;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_wr  = we_q;
          acc_rd  = ~we_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      valid_q <= acc_rd;
      err_q   <= set_err;
      if (acc_wr) begin
        mem_q[acc_idx] <= acc_dat;
      end
      if (acc_rd) begin
        rdata_q <= mem_q[acc_idx];
      end
    end
  end

  assign bus.stall = rstn
    && (((state_q == IDLE) && req) || (state_q == BUSY));
  assign bus.rd_data  = rdata_q;
  assign bus.rd_valid = valid_q;
  assign bus.err      = err_q;
endmodule
